// File: rtl/reg_sel_flag_bank_if.sv
// Control and status bundle for the register-select flag bank.
// The master is the datapath controller; the slave is the flag bank itself.
interface reg_sel_flag_bank_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic                 flag_clr;
  logic [NCH-1:0]       flag_tog;
  logic [NCH-1:0]       flag_ld;
  logic [NCH-1:0]       flag_ld_val;
  logic                 snap_save;
  logic                 snap_rest;
  logic [NCH-1:0]       flag;
  logic [NCH-1:0]       flag_prev;
  logic [NCH*CNT_W-1:0] tog_cnt;
  logic [NCH-1:0]       cnt_sat;
  logic                 snap_valid;

  modport master (
    output flag_clr, flag_tog, flag_ld, flag_ld_val, snap_save, snap_rest,
    input  flag, flag_prev, tog_cnt, cnt_sat, snap_valid
  );

  modport slave (
    input  flag_clr, flag_tog, flag_ld, flag_ld_val, snap_save, snap_rest,
    output flag, flag_prev, tog_cnt, cnt_sat, snap_valid
  );
endinterface

// File: rtl/reg_sel_flag_bank.sv
// Bank of register-select flags for the modular inverse/division datapath.
// Each flag says which physical register holds an operand (1 = primary,
// 0 = alternate). Adds explicit load, a one-deep snapshot for aborting an
// iteration, and a saturating per-channel toggle counter used to cross-check
// the swap count against the iteration count.
module reg_sel_flag_bank #(
  parameter int             NCH     = 4,
  parameter logic [NCH-1:0] RST_VAL = {NCH{1'b1}},
  parameter int             CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_sel_flag_bank_if.slave bus
);

  logic [NCH-1:0]            r_flag;
  logic [NCH-1:0]            r_flag_prev;
  logic [NCH-1:0]            r_snap;
  logic                      r_snap_valid;
  logic [NCH-1:0][CNT_W-1:0] r_cnt;
  logic [NCH-1:0]            r_cnt_sat;

  logic                      w_rest_en;
  logic                      w_save_en;
  logic [NCH-1:0]            w_flag_nxt;
  logic [NCH-1:0]            w_tog_app;
  logic [NCH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [NCH-1:0]            w_sat_nxt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state selection: clear > valid restore > load > toggle > hold.
  // A restore always blocks a same-cycle save, even if the snapshot is empty,
  // and a clear blocks a save so the snapshot survives the clear untouched.
  always_comb begin
    w_rest_en  = bus.snap_rest & r_snap_valid;
    w_save_en  = bus.snap_save & ~bus.snap_rest & ~bus.flag_clr;
    w_flag_nxt = r_flag;
    w_tog_app  = '0;
    w_cnt_nxt  = r_cnt;
    w_sat_nxt  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.flag_clr) begin
        w_flag_nxt[i] = RST_VAL[i];
      end else if (w_rest_en) begin
        w_flag_nxt[i] = r_snap[i];
      end else if (bus.flag_ld[i]) begin
        w_flag_nxt[i] = bus.flag_ld_val[i];
      end else if (bus.flag_tog[i]) begin
        w_flag_nxt[i] = ~r_flag[i];
        w_tog_app[i]  = 1'b1;
      end

      if (bus.flag_clr) begin
        w_cnt_nxt[i] = '0;
      end else if (w_tog_app[i]) begin
        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
      end
      w_sat_nxt[i] = &w_cnt_nxt[i];
    end
  end

  // State registers; reset overrides every other request in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag       <= RST_VAL;
      r_flag_prev  <= RST_VAL;
      r_snap       <= RST_VAL;
      r_snap_valid <= 1'b0;
      r_cnt        <= '0;
      r_cnt_sat    <= '0;
    end else begin
      r_flag      <= w_flag_nxt;
      r_flag_prev <= r_flag;
      r_cnt       <= w_cnt_nxt;
      r_cnt_sat   <= w_sat_nxt;
      if (w_save_en) begin
        r_snap       <= r_flag;
        r_snap_valid <= 1'b1;
      end
    end
  end

  assign bus.flag       = r_flag;
  assign bus.flag_prev  = r_flag_prev;
  assign bus.tog_cnt    = r_cnt;
  assign bus.cnt_sat    = r_cnt_sat;
  assign bus.snap_valid = r_snap_valid;

endmodule
